ibex_ex_result_buffer: RTL and testbench

Parametrised result buffer between the execute stage and register-file writeback. It accepts results from `NUM_SRC` execute units (ALU, multiply/divide, CHERI ALU, …) over valid/ready handshakes and arbitrates them with fixed priority. Accepted results are queued in a `DEPTH`-entry FIFO of capability-width words with exception vectors and destination register, then presented to writeback in order. It stops accepting new results behind a faulting result, and supports single-cycle flush.

---
 rtl/ibex_ex_result_buffer.sv | 140 ++++++++++++++
 tb/tb_ibex_ex_result_buffer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_ex_result_buffer.sv
// Result buffer between execute and writeback: fixed-priority capture from
// NUM_SRC producers into an in-order FIFO, blocking behind a faulting result.
module ibex_ex_result_buffer #(
  parameter int CAP_W   = 93,
  parameter int EXC_W   = 22,
  parameter int NUM_SRC = 3,
  parameter int DEPTH   = 2,
  localparam int SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_SRC-1:0]       src_valid_i,
  output logic [NUM_SRC-1:0]       src_ready_o,
  input  logic [NUM_SRC*CAP_W-1:0] src_data_i,
  input  logic [NUM_SRC-1:0]       src_wrote_cap_i,
  input  logic [NUM_SRC*EXC_W-1:0] src_exc_i,
  input  logic [NUM_SRC*5-1:0]     src_rd_i,
  input  logic                     flush_i,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output logic [CAP_W-1:0]         wb_data_o,
  output logic                     wb_wrote_cap_o,
  output logic [EXC_W-1:0]         wb_exc_o,
  output logic [4:0]               wb_rd_o,
  output logic [SRC_W-1:0]         wb_src_o,
  output logic [CNT_W-1:0]         count_o,
  output logic                     exc_pending_o
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [CAP_W-1:0] data_q [DEPTH];
  logic             cap_q  [DEPTH];
  logic [EXC_W-1:0] exc_q  [DEPTH];
  logic [4:0]       rd_q   [DEPTH];
  logic [SRC_W-1:0] src_q  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             exc_pending_q, exc_pending_d;

  logic               any_valid;
  logic [SRC_W-1:0]   grant_idx;
  logic [NUM_SRC-1:0] grant_oh;
  logic [CAP_W-1:0]   sel_data;
  logic               sel_cap;
  logic [EXC_W-1:0]   sel_exc;
  logic [4:0]         sel_rd;
  logic               pop, push, space, zero_rd;

  // Scan from the top so the lowest asserted channel is the last to win.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    any_valid = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    sel_data  = '0;
    sel_cap   = 1'b0;
    sel_exc   = '0;
    sel_rd    = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (src_valid_i[k]) begin
        any_valid   = 1'b1;
        grant_idx   = SRC_W'(k);
        grant_oh    = '0;
        grant_oh[k] = 1'b1;
        sel_data    = src_data_i[k*CAP_W +: CAP_W];
        sel_cap     = src_wrote_cap_i[k];
        sel_exc     = src_exc_i[k*EXC_W +: EXC_W];
        sel_rd      = src_rd_i[k*5 +: 5];
      end
    end
  end

  assign wb_valid_o  = (count_q != '0);
  assign pop         = wb_valid_o & wb_ready_i & ~flush_i;
  assign space       = (count_q < DEPTH_C) | (wb_valid_o & wb_ready_i);
  assign push        = any_valid & space & ~exc_pending_q & ~flush_i & ~rst_i;
  assign src_ready_o = push ? grant_oh : '0;
  assign zero_rd     = (sel_rd == 5'd0) && (sel_exc == '0);

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    exc_pending_d = exc_pending_q;
    if (flush_i) begin
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      exc_pending_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
      // The faulting entry is always the youngest, so it pops only as the last one.
      if (push && sel_exc != '0)               exc_pending_d = 1'b1;
      else if (pop && count_q == CNT_W'(1))    exc_pending_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      exc_pending_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      exc_pending_q <= exc_pending_d;
    end
  end

  // NOTE: storage is not reset; outputs are gated by occupancy, so stale words never leak.
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_q[wr_ptr_q] <= zero_rd ? '0 : sel_data;
      cap_q[wr_ptr_q]  <= zero_rd ? 1'b0 : sel_cap;
      exc_q[wr_ptr_q]  <= sel_exc;
      rd_q[wr_ptr_q]   <= sel_rd;
      src_q[wr_ptr_q]  <= grant_idx;
    end
  end

  assign wb_data_o      = wb_valid_o ? data_q[rd_ptr_q] : '0;
  assign wb_wrote_cap_o = wb_valid_o ? cap_q[rd_ptr_q]  : 1'b0;
  assign wb_exc_o       = wb_valid_o ? exc_q[rd_ptr_q]  : '0;
  assign wb_rd_o        = wb_valid_o ? rd_q[rd_ptr_q]   : '0;
  assign wb_src_o       = wb_valid_o ? src_q[rd_ptr_q]  : '0;
  assign count_o        = count_q;
  assign exc_pending_o  = exc_pending_q;

endmodule

// File: tb/tb_ibex_ex_result_buffer.sv
// Directed and randomized checks of ibex_ex_result_buffer against a queue-based
// reference model of the buffer's acceptance and delivery rules.
module tb_ibex_ex_result_buffer;

  localparam int CAP_W   = 93;
  localparam int EXC_W   = 22;
  localparam int NUM_SRC = 3;
  localparam int DEPTH   = 2;
  localparam int SRC_W   = 2;
  localparam int CNT_W   = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_SRC-1:0]       src_valid, src_ready, src_wrote_cap;
  logic [NUM_SRC*CAP_W-1:0] src_data;
  logic [NUM_SRC*EXC_W-1:0] src_exc;
  logic [NUM_SRC*5-1:0]     src_rd;
  logic                     flush, wb_valid, wb_ready, wb_wrote_cap, exc_pending;
  logic [CAP_W-1:0]         wb_data;
  logic [EXC_W-1:0]         wb_exc;
  logic [4:0]               wb_rd;
  logic [SRC_W-1:0]         wb_src;
  logic [CNT_W-1:0]         count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [CAP_W-1:0] data;
    logic             cap;
    logic [EXC_W-1:0] exc;
    logic [4:0]       rd;
    logic [SRC_W-1:0] src;
  } ent_t;
  ent_t model_q[$];

  always #5 clk = ~clk;

  ibex_ex_result_buffer #(
    .CAP_W(CAP_W), .EXC_W(EXC_W), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .src_valid_i(src_valid), .src_ready_o(src_ready),
    .src_data_i(src_data), .src_wrote_cap_i(src_wrote_cap),
    .src_exc_i(src_exc), .src_rd_i(src_rd),
    .flush_i(flush),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready),
    .wb_data_o(wb_data), .wb_wrote_cap_o(wb_wrote_cap),
    .wb_exc_o(wb_exc), .wb_rd_o(wb_rd), .wb_src_o(wb_src),
    .count_o(count), .exc_pending_o(exc_pending)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int k, input logic [CAP_W-1:0] d, input logic cap,
                         input logic [EXC_W-1:0] e, input logic [4:0] r);
    src_data[k*CAP_W +: CAP_W] = d;
    src_wrote_cap[k]           = cap;
    src_exc[k*EXC_W +: EXC_W]  = e;
    src_rd[k*5 +: 5]           = r;
  endtask

  // One randomized cycle: drive, check against the model, then advance the model.
  task automatic rand_cycle();
    logic [95:0]        r;
    logic [NUM_SRC-1:0] exp_ready;
    bit                 pending, pop, accept;
    int                 win;
    ent_t               e;
    src_valid = NUM_SRC'($urandom);
    for (int k = 0; k < NUM_SRC; k++) begin
      r = {$urandom, $urandom, $urandom};
      set_src(k, r[CAP_W-1:0], 1'($urandom),
              ($urandom_range(7) == 0) ? EXC_W'($urandom_range(1, 4000)) : '0,
              ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom));
    end
    wb_ready = 1'($urandom);
    flush    = ($urandom_range(31) == 0);
    #1;
    pending = (model_q.size() != 0) && (model_q[$].exc != '0);
    check("rnd_valid", wb_valid, model_q.size() != 0);
    check("rnd_count", count, model_q.size());
    check("rnd_pending", exc_pending, pending);
    if (model_q.size() != 0) begin
      check("rnd_data", wb_data, model_q[0].data);
      check("rnd_cap", wb_wrote_cap, model_q[0].cap);
      check("rnd_exc", wb_exc, model_q[0].exc);
      check("rnd_rd", wb_rd, model_q[0].rd);
      check("rnd_src", wb_src, model_q[0].src);
    end
    pop = (model_q.size() != 0) && wb_ready;
    win = -1;
    for (int k = NUM_SRC - 1; k >= 0; k--) if (src_valid[k]) win = k;
    accept = (win >= 0) && ((model_q.size() < DEPTH) || pop) && !pending && !flush;
    exp_ready = '0;
    if (accept) exp_ready[win] = 1'b1;
    check("rnd_ready", src_ready, exp_ready);
    if (flush) begin
      model_q.delete();
    end else begin
      if (pop) void'(model_q.pop_front());
      if (accept) begin
        e.exc  = src_exc[win*EXC_W +: EXC_W];
        e.rd   = src_rd[win*5 +: 5];
        e.src  = SRC_W'(win);
        e.data = (e.rd == 0 && e.exc == 0) ? '0 : src_data[win*CAP_W +: CAP_W];
        e.cap  = (e.rd == 0 && e.exc == 0) ? 1'b0 : src_wrote_cap[win];
        model_q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; wb_ready = 1'b0;
    src_valid = '1; src_data = '0; src_wrote_cap = '0; src_exc = '0; src_rd = '0;
    @(negedge clk); @(negedge clk);
    #1;
    check("rst_ready", src_ready, 3'b000);
    check("rst_valid", wb_valid, 1'b0);
    check("rst_count", count, 2'd0);
    check("rst_pending", exc_pending, 1'b0);
    check("rst_data", wb_data, '0);
    rst = 1'b0; src_valid = '0;

    // Single push from channel 1
    @(negedge clk);
    src_valid = 3'b010; set_src(1, 93'h1234, 1'b0, '0, 5'd5);
    #1 check("single_ready", src_ready, 3'b010);
    @(negedge clk);
    src_valid = '0;
    #1;
    check("single_valid", wb_valid, 1'b1);
    check("single_data", wb_data, 93'h1234);
    check("single_rd", wb_rd, 5'd5);
    check("single_src", wb_src, 2'd1);
    check("single_count", count, 2'd1);
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    #1 check("single_drained", count, 2'd0);

    // Priority and backpressure
    @(negedge clk);
    src_valid = 3'b111;
    set_src(0, 93'hA0, 1'b0, '0, 5'd7);
    set_src(1, 93'hB0, 1'b0, '0, 5'd8);
    set_src(2, 93'hC0, 1'b0, '0, 5'd9);
    #1 check("prio_ready0", src_ready, 3'b001);
    @(negedge clk);
    set_src(0, 93'hA1, 1'b0, '0, 5'd7);
    #1 check("prio_ready1", src_ready, 3'b001);
    @(negedge clk);
    #1;
    check("full_ready", src_ready, 3'b000);
    check("full_count", count, 2'd2);
    check("full_head", wb_data, 93'hA0);
    @(negedge clk);
    #1;
    check("full_hold_count", count, 2'd2);
    check("full_hold_head", wb_data, 93'hA0);
    wb_ready = 1'b1;
    set_src(0, 93'hA2, 1'b0, '0, 5'd7);
    #1 check("popfree_ready", src_ready, 3'b001);
    @(negedge clk);
    #1;
    check("thru_count", count, 2'd2);
    check("thru_head", wb_data, 93'hA1);
    src_valid = '0;
    @(negedge clk);
    #1 check("drain_head", wb_data, 93'hA2);
    @(negedge clk);
    wb_ready = 1'b0;
    #1 check("drain_count", count, 2'd0);

    // Exception blocking
    @(negedge clk);
    src_valid = 3'b100; set_src(2, 93'h77, 1'b0, 22'h000004, 5'd3);
    #1 check("exc_ready2", src_ready, 3'b100);
    @(negedge clk);
    src_valid = 3'b001; set_src(0, 93'h55, 1'b0, '0, 5'd1);
    #1;
    check("exc_block", src_ready, 3'b000);
    check("exc_pending", exc_pending, 1'b1);
    check("exc_head", wb_exc, 22'h000004);
    check("exc_src", wb_src, 2'd2);
    @(negedge clk);
    wb_ready = 1'b1;
    #1 check("exc_popcycle_ready", src_ready, 3'b000);
    @(negedge clk);
    wb_ready = 1'b0;
    #1;
    check("exc_cleared", exc_pending, 1'b0);
    check("exc_cleared_count", count, 2'd0);
    check("exc_unblock", src_ready, 3'b001);
    @(negedge clk);
    src_valid = '0;
    #1;
    check("exc_next_data", wb_data, 93'h55);
    check("exc_next_src", wb_src, 2'd0);
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;

    // rd zero forcing, then a faulting rd-zero entry keeps its data
    src_valid = 3'b001; set_src(0, 93'hFFFF, 1'b1, '0, 5'd0);
    @(negedge clk);
    src_valid = '0;
    #1;
    check("rd0_data", wb_data, '0);
    check("rd0_cap", wb_wrote_cap, 1'b0);
    wb_ready = 1'b1;
    src_valid = 3'b001; set_src(0, 93'hFFFF, 1'b1, 22'h1, 5'd0);
    @(negedge clk);
    src_valid = '0; wb_ready = 1'b0;
    #1;
    check("rd0exc_data", wb_data, 93'hFFFF);
    check("rd0exc_cap", wb_wrote_cap, 1'b1);
    check("rd0exc_count", count, 2'd1);
    check("rd0exc_pending", exc_pending, 1'b1);
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    #1 check("rd0exc_popclear", exc_pending, 1'b0);

    // Flush collision
    src_valid = 3'b001; set_src(0, 93'h9, 1'b0, '0, 5'd2);
    @(negedge clk);
    @(negedge clk);
    #1 check("flush_pre_count", count, 2'd2);
    flush = 1'b1; wb_ready = 1'b1;
    #1 check("flush_noack", src_ready, 3'b000);
    @(negedge clk);
    flush = 1'b0; src_valid = '0; wb_ready = 1'b0;
    #1;
    check("flush_count", count, 2'd0);
    check("flush_valid", wb_valid, 1'b0);

    // Asynchronous reset mid-stream
    src_valid = 3'b001; set_src(0, 93'h31, 1'b1, '0, 5'd6);
    @(negedge clk);
    src_valid = 3'b010; set_src(1, 93'h42, 1'b0, 22'h8, 5'd4);
    @(negedge clk);
    src_valid = 3'b111;
    #1;
    check("arst_pre_count", count, 2'd2);
    check("arst_pre_pending", exc_pending, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("arst_valid", wb_valid, 1'b0);
    check("arst_count", count, 2'd0);
    check("arst_pending", exc_pending, 1'b0);
    check("arst_ready", src_ready, 3'b000);
    check("arst_data", wb_data, '0);
    check("arst_cap", wb_wrote_cap, 1'b0);
    check("arst_exc", wb_exc, '0);
    check("arst_rd", wb_rd, '0);
    check("arst_src", wb_src, '0);
    @(negedge clk);
    rst = 1'b0; src_valid = '0;
    @(negedge clk);

    // Random traffic against the reference model
    model_q.delete();
    for (int i = 0; i < 600; i++) rand_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
